// File: rtl/dht11_scheduler.sv
// dht11_scheduler
//   Sequences the DHT11 reader block: merges periodic auto-triggers with host
//   requests, enforces the minimum inter-read gap, aborts hung reads by
//   timeout, retries failed reads and publishes validated results.
//
// Ports
//   clk, rst_n            system clock, synchronous active-low reset
//   enable                periodic auto-trigger enable (level)
//   req_cmd               host measurement request (single-cycle pulse)
//   sens_start            one-cycle start strobe to the reader
//   sens_rst_n            active-low reader reset, pulsed to abort a hung read
//   sens_ready            reader completion flag (level)
//   sens_data             reader result {temp, hum}; 0 means checksum failure
//   temp, hum             last good reading
//   meas_valid            one-cycle pulse: temp/hum updated
//   meas_err              one-cycle pulse: request abandoned after retries
//   err_code              last failure cause: 00 none, 01 timeout, 10 checksum
//   busy                  high whenever the controller is not idle
module dht11_scheduler #(
  parameter int unsigned PERIOD_CYCLES  = 200_000_000,
  parameter int unsigned MIN_GAP_CYCLES = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 30_000_000,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        req_cmd,
  output logic        sens_start,
  output logic        sens_rst_n,
  input  logic        sens_ready,
  input  logic [15:0] sens_data,
  output logic [7:0]  temp,
  output logic [7:0]  hum,
  output logic        meas_valid,
  output logic        meas_err,
  output logic [1:0]  err_code,
  output logic        busy
);

  localparam logic [31:0] PER_LAST = 32'(PERIOD_CYCLES - 1);
  localparam logic [31:0] GAP_SAT  = 32'(MIN_GAP_CYCLES);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  RETRY_LIM = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE, TRIG, WAIT, ABORT, CHECK, RETRY, GAP
  } state_t;

  state_t      state, state_nx;
  logic [31:0] per_cnt;
  logic [31:0] gap_cnt;
  logic [31:0] tmo_cnt;
  logic        pend_auto, pend_cmd;
  logic        ready_q;
  logic        abort_cnt;
  logic [2:0]  retry_cnt;
  logic [15:0] cap;

  logic gap_ok, ready_rise, tmo_hit, trig_entry, per_wrap, cap_good, retry_more;

  assign gap_ok     = (gap_cnt == GAP_SAT);
  assign ready_rise = sens_ready & ~ready_q;
  assign tmo_hit    = (tmo_cnt == TMO_LAST);
  assign per_wrap   = enable && (per_cnt == PER_LAST);
  assign cap_good   = (cap != 16'h0000);
  assign retry_more = (retry_cnt < RETRY_LIM);
  // TRIG never loops on itself, so any cycle heading into TRIG is an entry.
  assign trig_entry = (state_nx == TRIG);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if ((pend_auto | pend_cmd) && gap_ok) state_nx = TRIG;
      TRIG:    state_nx = WAIT;
      // A ready edge arriving on the timeout cycle still counts as success.
      WAIT:    if (ready_rise)   state_nx = CHECK;
               else if (tmo_hit) state_nx = ABORT;
      ABORT:   if (abort_cnt)    state_nx = RETRY;
      CHECK:   state_nx = cap_good ? IDLE : RETRY;
      RETRY:   state_nx = retry_more ? GAP : IDLE;
      GAP:     if (gap_ok)       state_nx = TRIG;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      per_cnt    <= '0;
      gap_cnt    <= '0;
      tmo_cnt    <= '0;
      pend_auto  <= 1'b0;
      pend_cmd   <= 1'b0;
      ready_q    <= 1'b0;
      abort_cnt  <= 1'b0;
      retry_cnt  <= '0;
      cap        <= '0;
      sens_start <= 1'b0;
      sens_rst_n <= 1'b1;
      temp       <= '0;
      hum        <= '0;
      meas_valid <= 1'b0;
      meas_err   <= 1'b0;
      err_code   <= '0;
    end else begin
      ready_q <= sens_ready;

      if (!enable || per_wrap) per_cnt <= '0;
      else                     per_cnt <= per_cnt + 32'd1;

      // Clearing on TRIG entry wins over a same-cycle request: the read
      // being launched already covers it.
      if (trig_entry)    pend_auto <= 1'b0;
      else if (per_wrap) pend_auto <= 1'b1;
      if (trig_entry)    pend_cmd <= 1'b0;
      else if (req_cmd)  pend_cmd <= 1'b1;

      if (trig_entry)          gap_cnt <= '0;
      else if (!gap_ok)        gap_cnt <= gap_cnt + 32'd1;

      if (state == TRIG)       tmo_cnt <= '0;
      else if (state == WAIT)  tmo_cnt <= tmo_cnt + 32'd1;

      if (state == ABORT) abort_cnt <= ~abort_cnt;
      else                abort_cnt <= 1'b0;

      if (state == WAIT && ready_rise) cap <= sens_data;

      sens_start <= (state == TRIG);
      sens_rst_n <= (state != ABORT);
      meas_valid <= (state == CHECK) && cap_good;
      meas_err   <= (state == RETRY) && !retry_more;

      if (state == WAIT && !ready_rise && tmo_hit) err_code <= 2'b01;

      if (state == CHECK) begin
        if (cap_good) begin
          temp      <= cap[15:8];
          hum       <= cap[7:0];
          err_code  <= 2'b00;
          retry_cnt <= '0;
        end else begin
          err_code  <= 2'b10;
        end
      end

      if (state == RETRY) begin
        if (retry_more) retry_cnt <= retry_cnt + 3'd1;
        else            retry_cnt <= '0;
      end
    end
  end

endmodule

// File: doc/dht11_scheduler.md
Name: dht11_scheduler

Overview:
- Controller that sequences the DHT11 single-wire reader block.
- Merges periodic auto-triggers with host (UART-command) requests into one measurement stream.
- Enforces the sensor's minimum inter-read gap, detects hung transactions by timeout, retries failed reads, and publishes validated temperature/humidity with status pulses.
- Sits between the command/UART front end and the DHT11 reader.

Parameters:
- PERIOD_CYCLES, 200_000_000, auto-trigger period in clk cycles (2 s at 100 MHz).
- MIN_GAP_CYCLES, 100_000_000, minimum cycles from one sens_start to the next, including retries.
- TIMEOUT_CYCLES, 30_000_000, maximum cycles from sens_start to reader ready.
- MAX_RETRY, 2, extra attempts after a failed read (0..7).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset, synchronous, active-low.
- enable  in  1  periodic auto-trigger enable (level).
- req_cmd  in  1  host measurement request, single-cycle pulse.
- sens_start  out  1  start strobe to reader (drives reader's request input).
- sens_rst_n  out  1  active-low reset to reader, used to abort a hung transaction.
- sens_ready  in  1  reader completion flag (level).
- sens_data  in  16  reader result {temperature[15:8], humidity[7:0]}; 16'h0000 means checksum failure.
- temp  out  8  last good temperature, °C integer.
- hum  out  8  last good humidity, % integer.
- meas_valid  out  1  one-cycle pulse: temp/hum updated.
- meas_err  out  1  one-cycle pulse: request abandoned after retries.
- err_code  out  2  cause of last failure: 00 none, 01 timeout, 10 checksum; held until the next meas_valid/meas_err.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE; all outputs 0 except sens_rst_n=1.
  - pending flags, retry count and period counter cleared.
  - gap counter cleared to 0, so the first read waits MIN_GAP_CYCLES after reset (sensor power-up settle).
  - Reset mid-operation abandons the transaction with no meas_valid/meas_err pulse.
- Period counter:
  - Counts while enable=1 and holds at 0 while enable=0.
  - At PERIOD_CYCLES-1 it wraps to 0 and sets pend_auto.
- Request latching:
  - req_cmd=1 sets pend_cmd on the next edge.
  - Both flags clear on entry to TRIG. Any number of requests during one transaction collapse to one follow-up measurement.
  - Simultaneous auto and cmd requests produce one measurement.
- Gap counter:
  - 32-bit; cleared on entry to TRIG, otherwise increments, saturating at MIN_GAP_CYCLES.
  - gap_ok = (gap == MIN_GAP_CYCLES).
- FSM (registered outputs):
  - IDLE: if (pend_auto|pend_cmd) and gap_ok, go to TRIG; else stay. Latency: req_cmd at edge k gives sens_start high in the cycle after edge k+2 when gap_ok is already true.
  - TRIG: sens_start=1 for exactly one cycle; timeout counter cleared; go to WAIT.
  - WAIT: detect the sens_ready rising edge (registered previous sample).
    - On the edge: capture sens_data and go to CHECK.
    - Timeout counter reaching TIMEOUT_CYCLES-1 with no edge: set err_code=01 and go to ABORT.
    - An edge on the same cycle as the timeout wins (go to CHECK).
  - ABORT: sens_rst_n=0 for 2 cycles, then go to RETRY.
  - CHECK:
    - Captured data != 0: temp/hum updated, meas_valid=1 for one cycle, err_code=00, retry count cleared, go to IDLE.
    - Captured data == 0: err_code=10, go to RETRY.
  - RETRY:
    - retry count < MAX_RETRY: increment it and go to GAP.
    - Otherwise: meas_err=1 for one cycle, retry count cleared, go to IDLE. temp/hum keep their old values.
  - GAP: wait for gap_ok, then go to TRIG. Pending flags are not required for a retry.
- A genuine 0 °C / 0 % reading is indistinguishable from a checksum failure and is treated as a failure.
- sens_ready rising outside WAIT is ignored.
- meas_valid and meas_err are never high together.

Test Plan (PERIOD_CYCLES=100, MIN_GAP_CYCLES=20, TIMEOUT_CYCLES=50, MAX_RETRY=2, behavioural reader model):
1. Release reset, enable=0, req_cmd pulse at cycle 5 -> no sens_start before gap saturates (cycle ≥20); exactly one 1-cycle sens_start. Model returns 16'h1A2D 30 cycles later -> meas_valid pulse, temp=0x1A, hum=0x2D, err_code=00, busy falls.
2. enable=1, no req_cmd -> sens_start every 100 cycles (periodic spacing ≥20). With req_cmd coinciding with the period wrap -> a single sens_start, not two.
3. Model returns 16'h0000 twice, then 16'h1B30 -> three sens_start pulses, each ≥20 cycles apart; one meas_valid with temp=0x1B; no meas_err.
4. Model never raises ready -> per attempt, sens_rst_n low for 2 cycles 50 cycles after sens_start; three attempts total; meas_err pulse with err_code=01; temp/hum unchanged.
5. Three req_cmd pulses during WAIT -> exactly one follow-up measurement after completion.
6. rst_n low mid-WAIT -> next edge gives IDLE, busy=0, no status pulse; next request waits a full 20-cycle gap.
